alu_seq: RTL and testbench
==========================

# alu_seq

Sequential ALU stage that sits directly upstream of the 8-bit accumulator in the LIPSI core. It combines the current accumulator value with an operand using single-cycle arithmetic/logic ops or an 8-cycle shift-add multiply. It presents a registered result together with a one-cycle load strobe that drives the accumulator's data input and load enable. It also keeps the carry and zero flags used by the core's conditional branches.

## Interface
Parameters: none; datapath fixed at 8 bits.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active-high
- start  in  1  request strobe; sampled only when busy=0
- op  in  3  operation: 000 ADD, 001 SUB, 010 ADC, 011 SBB, 100 AND, 101 OR, 110 XOR, 111 MUL
- a  in  8  left operand (accumulator output)
- b  in  8  right operand (memory/immediate)
- result  out  8  registered result; wired to accumulator data input
- acc_load  out  1  one-cycle strobe; wired to accumulator load enable
- busy  out  1  high while MUL is in progress
- carry  out  1  carry/borrow flag, registered
- zero  out  1  high when last committed result == 0, registered

## Operation
- States: IDLE, MUL. Reset value of all outputs is 0 and the state is IDLE; the internal multiplicand, multiplier, product and counter registers are cleared.
- Behaviour in IDLE with start=1:
  - For op 000–110, compute the result in the same cycle.
  - On that edge, update result, carry, zero, and set acc_load=1.
  - Stay in IDLE.
- Arithmetic (all 9-bit internally):
  - ADD: {c,r} = a + b.
  - SUB: {c,r} = a - b; carry = borrow, i.e. 1 iff a < b.
  - ADC: a + b + carry.
  - SBB: a - b - carry; carry = borrow.
  - Results wrap modulo 256.
- Logic ops (AND/OR/XOR): result updated, carry unchanged, zero updated.
- MUL:
  - IDLE, start=1, op=111: latch a and b, clear the 16-bit product, counter=0, busy=1, go to MUL. acc_load stays 0.
  - Each edge in MUL performs one shift-add step (LSB of multiplier first) and increments the counter.
  - On the 8th step:
    - result = product[7:0]
    - carry = 1 iff product[15:8] != 0
    - zero = (product[7:0] == 0)
    - acc_load = 1, busy = 0, return to IDLE
- acc_load is high for exactly one cycle per completed operation and is 0 otherwise.
- result, carry and zero hold their values between completions.
- start while busy=1 is ignored; the request is not queued and the in-flight multiply is unaffected.
- a and b are don't-care during MUL (operands are latched at start).
- Reset asserted mid-multiply aborts immediately: IDLE, all outputs 0, no acc_load is issued.

## Timing
- Single-cycle ops:
  - start sampled at edge N; result and acc_load valid after edge N.
  - The accumulator captures at edge N+1.
- MUL:
  - start sampled at edge N; busy=1 after edge N.
  - Steps occur on edges N+1..N+8.
  - result, acc_load=1 and busy=0 appear after edge N+8.
  - The accumulator captures at edge N+9.
- Back-to-back: start may be asserted in the same cycle acc_load=1. Consecutive single-cycle ops sustain one result per cycle, with acc_load held high continuously.
- The flags used by ADC/SBB are the values registered at the previous completion.
- busy and acc_load are never high in the same cycle.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> result=0, acc_load=0, busy=0, carry=0, zero=0 immediately, without waiting for a clock edge.
- ADD/ADC chain: ADD a=0xF0 b=0x20 -> result=0x10, carry=1, acc_load one cycle; then ADC a=0x01 b=0x01 -> result=0x03, carry=0.
- SUB/SBB and zero: SUB a=0x05 b=0x05 -> result=0x00, zero=1, carry=0; SUB a=0x03 b=0x04 -> 0xFF, carry=1; SBB a=0x10 b=0x00 -> 0x0F.
- Logic: carry=1 beforehand, XOR a=0xAA b=0xFF -> result=0x55, carry stays 1, zero=0.
- MUL: a=0x12 b=0x10 -> busy for 8 cycles, then result=0x20, carry=1 (product 0x0120), acc_load pulse on cycle 9 after start. Also a=0x07 b=0x06 -> 0x2A, carry=0. A start pulse at cycle 4 is ignored.
- Abort: start MUL, assert reset after 3 steps -> no acc_load; a subsequent ADD 0x01+0x01 -> result=0x02 with carry=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the LIPSI control path and alu_seq.
//   master (requester): drives start, op, a, b; observes result, acc_load, busy, carry, zero
//   slave  (alu_seq)  : the reverse directions
interface alu_seq_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic       acc_load;
  logic       busy;
  logic       carry;
  logic       zero;

  modport master (
    output start, op, a, b,
    input  result, acc_load, busy, carry, zero
  );

  modport slave (
    input  start, op, a, b,
    output result, acc_load, busy, carry, zero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU stage feeding the 8-bit LIPSI accumulator.
//   clk    : system clock, rising edge
//   reset  : asynchronous reset, active-high
//   bus    : alu_seq_if.slave
//            start/op/a/b in  -> request (sampled only while not busy)
//            result/acc_load  -> registered result + one-cycle load strobe
//            busy             -> high while the 8-step multiply runs
//            carry/zero       -> registered flags for conditional branches
// Single-cycle ops (ADD/SUB/ADC/SBB/AND/OR/XOR) commit on the start edge.
// MUL latches its operands on the start edge, then runs one shift-add step
// per clock and commits on the 8th step.
module alu_seq (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t      state;
  logic [7:0]  result_p0;
  logic        carry_p0;
  logic        zero_p0;
  logic        vld_p0;
  logic        busy_p0;
  logic [15:0] mcand_p0;
  logic [7:0]  mplier_p0;
  logic [15:0] product_p0;
  logic [2:0]  cnt_p0;

  logic [8:0]  alu_sum;
  logic        alu_is_logic;
  logic [15:0] product_nxt;

  // One shift-add step: add the (already shifted) multiplicand when the
  // current multiplier LSB is set.
  function automatic logic [15:0] mul_step(input logic [15:0] prod,
                                           input logic [15:0] mcand,
                                           input logic        lsb);
    return lsb ? (prod + mcand) : prod;
  endfunction

  // Bit 8 of the 9-bit difference is the borrow, so SUB/SBB carry = borrow.
  always_comb begin
    alu_sum      = 9'd0;
    alu_is_logic = 1'b0;
    case (bus.op)
      OP_ADD: alu_sum = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB: alu_sum = {1'b0, bus.a} - {1'b0, bus.b};
      OP_ADC: alu_sum = {1'b0, bus.a} + {1'b0, bus.b} + {8'd0, carry_p0};
      OP_SBB: alu_sum = {1'b0, bus.a} - {1'b0, bus.b} - {8'd0, carry_p0};
      OP_AND: begin alu_sum = {1'b0, bus.a & bus.b}; alu_is_logic = 1'b1; end
      OP_OR:  begin alu_sum = {1'b0, bus.a | bus.b}; alu_is_logic = 1'b1; end
      OP_XOR: begin alu_sum = {1'b0, bus.a ^ bus.b}; alu_is_logic = 1'b1; end
      default: alu_sum = 9'd0;
    endcase
  end

  assign product_nxt = mul_step(product_p0, mcand_p0, mplier_p0[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      result_p0  <= 8'd0;
      carry_p0   <= 1'b0;
      zero_p0    <= 1'b0;
      vld_p0     <= 1'b0;
      busy_p0    <= 1'b0;
      mcand_p0   <= 16'd0;
      mplier_p0  <= 8'd0;
      product_p0 <= 16'd0;
      cnt_p0     <= 3'd0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              mcand_p0   <= {8'd0, bus.a};
              mplier_p0  <= bus.b;
              product_p0 <= 16'd0;
              cnt_p0     <= 3'd0;
              busy_p0    <= 1'b1;
              state      <= MUL;
            end else begin
              result_p0 <= alu_sum[7:0];
              zero_p0   <= (alu_sum[7:0] == 8'd0);
              if (!alu_is_logic)
                carry_p0 <= alu_sum[8];
              vld_p0    <= 1'b1;
            end
          end
        end
        MUL: begin
          product_p0 <= product_nxt;
          mcand_p0   <= {mcand_p0[14:0], 1'b0};
          mplier_p0  <= {1'b0, mplier_p0[7:1]};
          cnt_p0     <= cnt_p0 + 3'd1;
          if (cnt_p0 == 3'd7) begin
            result_p0 <= product_nxt[7:0];
            carry_p0  <= |product_nxt[15:8];
            zero_p0   <= (product_nxt[7:0] == 8'd0);
            vld_p0    <= 1'b1;
            busy_p0   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result   = result_p0;
  assign bus.carry    = carry_p0;
  assign bus.zero     = zero_p0;
  assign bus.acc_load = vld_p0;
  assign bus.busy     = busy_p0;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq. An arithmetic reference model tracks
// the expected outputs every cycle; literal checks pin the model to known values.
module tb_alu_seq;

  logic clk;
  logic reset;
  alu_seq_if bus ();

  alu_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic, multiply as a*b with a countdown.
  int m_res, m_prod, m_left, x, y, ci;
  bit m_c, m_z, m_ld, m_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_res = 0; m_c = 0; m_z = 0; m_ld = 0; m_busy = 0; m_left = 0; m_prod = 0;
    end else begin
      m_ld = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_ld   = 1;
          m_res  = m_prod % 256;
          m_c    = (m_prod >= 256);
          m_z    = (m_res == 0);
        end
      end else if (bus.start === 1'b1) begin
        x = int'(bus.a); y = int'(bus.b); ci = int'(m_c);
        case (bus.op)
          3'd0: begin m_res = (x + y) % 256;            m_c = (x + y) > 255;      end
          3'd1: begin m_res = (x - y + 256) % 256;      m_c = (x < y);            end
          3'd2: begin m_res = (x + y + ci) % 256;       m_c = (x + y + ci) > 255; end
          3'd3: begin m_res = (x - y - ci + 512) % 256; m_c = (x < y + ci);       end
          3'd4: m_res = x & y;
          3'd5: m_res = x | y;
          3'd6: m_res = x ^ y;
          default: begin m_prod = x * y; m_left = 8; m_busy = 1; end
        endcase
        if (bus.op != 3'd7) begin
          m_z  = (m_res == 0);
          m_ld = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_result",   {8'd0, bus.result}, 16'(m_res));
    check("cmp_carry",    {15'd0, bus.carry},    {15'd0, m_c});
    check("cmp_zero",     {15'd0, bus.zero},     {15'd0, m_z});
    check("cmp_acc_load", {15'd0, bus.acc_load}, {15'd0, m_ld});
    check("cmp_busy",     {15'd0, bus.busy},     {15'd0, m_busy});
    check("cmp_excl",     {15'd0, bus.busy & bus.acc_load}, 16'd0);
  end

  // Drive one single-cycle request; returns 1ns after the committing edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] r, input logic c,
                            input logic z, input logic ld, input logic bsy);
    check({tag, "_result"},   {8'd0, bus.result},    {8'd0, r});
    check({tag, "_carry"},    {15'd0, bus.carry},    {15'd0, c});
    check({tag, "_zero"},     {15'd0, bus.zero},     {15'd0, z});
    check({tag, "_acc_load"}, {15'd0, bus.acc_load}, {15'd0, ld});
    check({tag, "_busy"},     {15'd0, bus.busy},     {15'd0, bsy});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 8'd0; bus.b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // ADD / ADC chain
    issue(3'b000, 8'hF0, 8'h20);
    check_outs("add", 8'h10, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("add_ld_drop", {15'd0, bus.acc_load}, 16'd0);
    issue(3'b010, 8'h01, 8'h01);
    check_outs("adc", 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);

    // SUB / SBB / zero
    issue(3'b001, 8'h05, 8'h05);
    check_outs("sub_eq", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(3'b001, 8'h03, 8'h04);
    check_outs("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(3'b011, 8'h10, 8'h00);
    check_outs("sbb", 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);

    // Logic op keeps carry
    issue(3'b000, 8'hFF, 8'h01);
    check_outs("add_wrap", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(3'b110, 8'hAA, 8'hFF);
    check_outs("xor", 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back single-cycle ops, start held high
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 8'h0F; bus.b = 8'hF0;
    @(posedge clk); #1;
    check_outs("b2b_or", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.op = 3'b100;
    @(posedge clk); #1;
    check_outs("b2b_and", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.op = 3'b000; bus.a = 8'h7F; bus.b = 8'h01;
    @(posedge clk); #1;
    check_outs("b2b_add", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;

    // MUL 0x12 * 0x10 = 0x0120 with an ignored start at cycle 4
    issue(3'b111, 8'h12, 8'h10);
    check_outs("mul1_start", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) begin
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'h01; bus.b = 8'h01;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("mul1_busy",     {15'd0, bus.busy},     16'd1);
      check("mul1_acc_load", {15'd0, bus.acc_load}, 16'd0);
    end
    @(posedge clk); #1;
    check_outs("mul1_done", 8'h20, 1'b1, 1'b0, 1'b1, 1'b0);

    // MUL 0x07 * 0x06 started in the acc_load cycle of the previous one
    bus.start = 1'b1; bus.op = 3'b111; bus.a = 8'h07; bus.b = 8'h06;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
    check_outs("mul2_start", 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check_outs("mul2_last", 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_outs("mul2_done", 8'h2A, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort a multiply after 3 steps with an asynchronous mid-cycle reset
    issue(3'b111, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_outs("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_load", {15'd0, bus.acc_load}, 16'd0);
    issue(3'b000, 8'h01, 8'h01);
    check_outs("post_abort_add", 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
